// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word slave.
//   SPI_MODE0..3    : {cpol, cpha} encodings of the four SPI modes
//   frame_state_e   : frame tracking states of the slave
//   cnt_width()     : width of the bit counter for a given word width
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // StDisarmed: waiting to see ssel_n high after reset before trusting a falling edge.
  typedef enum logic [1:0] {StDisarmed, StIdle, StActive} frame_state_e;

  function automatic int unsigned cnt_width(input int unsigned dw);
    return (dw <= 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser with a history flop for edge detection.
//   clk, reset : system clock, asynchronous active-high reset
//   d_i        : asynchronous input
//   q_o        : synchronised value (last sync stage)
//   prev_o     : q_o delayed by one clk
module spi_sync #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic prev_o
);

  logic [Stages-1:0] stage_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= {Stages{RstVal}};
      hist_q  <= RstVal;
    end else begin
      stage_q <= {stage_q[Stages-2:0], d_i};
      hist_q  <= stage_q[Stages-1];
    end
  end

  assign q_o    = stage_q[Stages-1];
  assign prev_o = hist_q;

endmodule

// File: rtl/spi_slave_word.sv
// SPI slave with configurable word width, runtime mode 0-3 and MSB/LSB-first order.
// SCK/SSEL/MOSI are oversampled in the clk domain.
//   clk, reset        : system clock (>= 4x SCK), asynchronous active-high reset
//   sck, ssel_n, mosi : SPI bus inputs from the master (asynchronous)
//   miso, miso_oe     : slave data out and its tri-state enable (high while frame active)
//   cpol, cpha        : SPI mode, latched at frame start
//   tx_data/valid/ready : one-entry transmit holding register write port
//   rx_data, rx_valid : last complete received word and its one-cycle strobe
//   frame_start/end   : one-cycle pulses on SSEL assertion / deassertion
//   tx_underrun       : shifter loaded with zeros because holding was empty
//   rx_partial        : frame ended with an incomplete word
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned SYNC      = 2,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          ssel_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic          cpol,
  input  logic          cpha,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_start,
  output logic          frame_end,
  output logic          tx_underrun,
  output logic          rx_partial
);

  localparam int unsigned     CW      = cnt_width(DW);
  localparam logic [CW-1:0]   LastBit = CW'(DW - 1);

  logic sck_s, sck_prev, ssel_s, ssel_prev, mosi_s, mosi_prev_unused;

  spi_sync #(.Stages(SYNC), .RstVal(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d_i(sck), .q_o(sck_s), .prev_o(sck_prev)
  );
  spi_sync #(.Stages(SYNC), .RstVal(1'b1)) u_sync_ssel (
    .clk(clk), .reset(reset), .d_i(ssel_n), .q_o(ssel_s), .prev_o(ssel_prev)
  );
  spi_sync #(.Stages(SYNC), .RstVal(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(mosi), .q_o(mosi_s), .prev_o(mosi_prev_unused)
  );

  // Marks when the synchroniser holds real samples rather than its reset values, so a
  // select held low across reset release is not mistaken for an idle-high line.
  logic [SYNC:0] fill_q;

  frame_state_e  state_q, state_d;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] rx_sh_q, rx_sh_next, tx_sh_q, tx_sh_shifted, hold_q;
  logic          hold_full_q;

  logic ssel_fall, ssel_rise, sck_edge, lead, sample_on_lead;
  logic start_frame, end_frame, bit_edge, sample, shift, word_done, load, wr_acc;

  assign ssel_fall = ssel_prev & ~ssel_s;
  assign ssel_rise = ~ssel_prev & ssel_s;
  assign sck_edge  = sck_s ^ sck_prev;
  assign lead      = (sck_s != mode_q[1]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StDisarmed;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= {fill_q[SYNC-1:0], 1'b1};
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDisarmed: if (fill_q[SYNC] && ssel_s) state_d = StIdle;
      StIdle:     if (ssel_fall) state_d = StActive;
      StActive:   if (ssel_rise) state_d = StIdle;
      default:    state_d = StDisarmed;
    endcase
  end

  // Decoded frame actions
  always_comb begin
    sample_on_lead = 1'b1;
    unique case (mode_q)
      SPI_MODE0, SPI_MODE2: sample_on_lead = 1'b1;
      SPI_MODE1, SPI_MODE3: sample_on_lead = 1'b0;
    endcase
    start_frame = (state_q == StIdle) && ssel_fall;
    end_frame   = (state_q == StActive) && ssel_rise;
    // Frame end takes priority over a coincident SCK edge.
    bit_edge    = (state_q == StActive) && !ssel_rise && sck_edge;
    sample      = bit_edge && (lead == sample_on_lead);
    shift       = bit_edge && (lead != sample_on_lead);
    word_done   = sample && (cnt_q == LastBit);
    load        = start_frame || word_done;
    wr_acc      = tx_valid && !hold_full_q;
  end

  always_comb begin
    if (LSB_FIRST) begin
      rx_sh_next    = {mosi_s, rx_sh_q[DW-1:1]};
      tx_sh_shifted = {1'b0, tx_sh_q[DW-1:1]};
    end else begin
      rx_sh_next    = {rx_sh_q[DW-2:0], mosi_s};
      tx_sh_shifted = {tx_sh_q[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= SPI_MODE0;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      tx_underrun <= 1'b0;
      rx_partial  <= 1'b0;
    end else begin
      if (start_frame) mode_q <= {cpol, cpha};

      if (start_frame || end_frame) cnt_q <= '0;
      else if (sample)              cnt_q <= word_done ? '0 : cnt_q + 1'b1;

      if (sample) rx_sh_q <= rx_sh_next;
      if (word_done) rx_data <= rx_sh_next;

      // A load always empties holding; a write in the same cycle can only land if it
      // was already empty, in which case the load itself takes zeros.
      if (load)        hold_full_q <= wr_acc;
      else if (wr_acc) hold_full_q <= 1'b1;
      if (wr_acc) hold_q <= tx_data;

      // With count 0 the freshly loaded word is already on miso, so that shift is skipped.
      if (load)                      tx_sh_q <= hold_full_q ? hold_q : '0;
      else if (shift && cnt_q != '0) tx_sh_q <= tx_sh_shifted;

      rx_valid    <= word_done;
      frame_start <= start_frame;
      frame_end   <= end_frame;
      tx_underrun <= load && !hold_full_q;
      rx_partial  <= end_frame && (cnt_q != '0);
    end
  end

  // Outputs
  always_comb begin
    miso_oe  = (state_q == StActive);
    miso     = miso_oe && (LSB_FIRST ? tx_sh_q[0] : tx_sh_q[DW-1]);
    tx_ready = !hold_full_q;
  end

endmodule

// File: tb/tb_spi_slave_word.sv
module tb_spi_slave_word;

  logic clk = 1'b0;
  logic reset, sck, mosi, cpol, cpha;
  logic [1:0] ssel_n, tx_valid;
  logic [1:0] miso, miso_oe, tx_ready, rx_valid, frame_start, frame_end, tx_underrun, rx_partial;
  logic [7:0]  tx_data8, rx_data8;
  logic [15:0] tx_data16, rx_data16;

  int total = 0;
  int bad = 0;

  // Reference model: holding register contents and expected pulse counts per DUT.
  logic        hold_full [2];
  logic [31:0] hold_val [2];
  int exp_fs [2], exp_fe [2], exp_rv [2], exp_ur [2], exp_pt [2];
  int obs_fs [2], obs_fe [2], obs_rv [2], obs_ur [2], obs_pt [2], obs_pt_alone [2];
  logic [31:0] rxq0 [$];
  logic [31:0] rxq1 [$];

  always #5 clk = ~clk;

  spi_slave_word #(.DW(8), .SYNC(2), .LSB_FIRST(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .sck(sck), .ssel_n(ssel_n[0]), .mosi(mosi),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data8), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data8), .rx_valid(rx_valid[0]), .frame_start(frame_start[0]),
    .frame_end(frame_end[0]), .tx_underrun(tx_underrun[0]), .rx_partial(rx_partial[0])
  );

  spi_slave_word #(.DW(16), .SYNC(2), .LSB_FIRST(1'b1)) u_dut16 (
    .clk(clk), .reset(reset), .sck(sck), .ssel_n(ssel_n[1]), .mosi(mosi),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data16), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data16), .rx_valid(rx_valid[1]), .frame_start(frame_start[1]),
    .frame_end(frame_end[1]), .tx_underrun(tx_underrun[1]), .rx_partial(rx_partial[1])
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (frame_start[d]) obs_fs[d]++;
      if (frame_end[d])   obs_fe[d]++;
      if (rx_valid[d])    obs_rv[d]++;
      if (tx_underrun[d]) obs_ur[d]++;
      if (rx_partial[d])  obs_pt[d]++;
      if (rx_partial[d] && !frame_end[d]) obs_pt_alone[d]++;
    end
    if (rx_valid[0]) rxq0.push_back({24'd0, rx_data8});
    if (rx_valid[1]) rxq1.push_back({16'd0, rx_data16});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_m(input int d);
    logic [31:0] v;
    if (hold_full[d]) v = hold_val[d];
    else begin
      v = '0;
      exp_ur[d]++;
    end
    hold_full[d] = 1'b0;
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_m(input int d, input logic [31:0] v);
    @(negedge clk);
    tx_valid[d] = 1'b1;
    if (d == 0) tx_data8 = v[7:0];
    else        tx_data16 = v[15:0];
    @(negedge clk);
    tx_valid[d] = 1'b0;
    if (!hold_full[d]) begin
      hold_full[d] = 1'b1;
      hold_val[d]  = v;
    end
    chk("tx_ready_after_write", {31'd0, tx_ready[d]}, {31'd0, !hold_full[d]});
  endtask

  task automatic chk_counts(input int d, input string tag);
    chk({tag, "_frame_start"}, obs_fs[d], exp_fs[d]);
    chk({tag, "_frame_end"}, obs_fe[d], exp_fe[d]);
    chk({tag, "_rx_valid_cnt"}, obs_rv[d], exp_rv[d]);
    chk({tag, "_tx_underrun_cnt"}, obs_ur[d], exp_ur[d]);
    chk({tag, "_rx_partial_cnt"}, obs_pt[d], exp_pt[d]);
    chk({tag, "_partial_without_end"}, obs_pt_alone[d], 0);
  endtask

  // One master frame: nbits on the wire (up to two words), optional holding write after bit wr_at.
  task automatic run_frame(input int d, input logic [1:0] mode, input int nbits,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input int wr_at, input logic [31:0] wr_val, input string tag);
    int dw, nw, k, j, pos;
    logic pol, pha, b;
    logic [31:0] exp_tx [3];
    logic [31:0] got [3];
    logic [31:0] rxw;
    dw  = (d == 1) ? 16 : 8;
    pol = mode[1];
    pha = mode[0];
    for (int i = 0; i < 3; i++) begin
      got[i]    = '0;
      exp_tx[i] = '0;
    end
    cpol = pol;
    cpha = pha;
    sck  = pol;
    wait_clk(4);
    ssel_n[d] = 1'b0;
    exp_fs[d]++;
    exp_tx[0] = load_m(d);
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      k   = i / dw;
      j   = i % dw;
      pos = (d == 1) ? j : dw - 1 - j;
      b   = (k == 0) ? w0[pos] : w1[pos];
      if (!pha) begin
        mosi = b;
        wait_clk(4);
        got[k][pos] = miso[d];
        sck = ~pol;
        wait_clk(8);
        sck = pol;
        wait_clk(4);
      end else begin
        sck  = ~pol;
        mosi = b;
        wait_clk(8);
        got[k][pos] = miso[d];
        sck = pol;
        wait_clk(8);
      end
      if (j == dw - 1) exp_tx[k + 1] = load_m(d);
      if (i == wr_at) wr_m(d, wr_val);
    end
    wait_clk(4);
    chk({tag, "_miso_oe_active"}, {31'd0, miso_oe[d]}, 32'd1);
    ssel_n[d] = 1'b1;
    exp_fe[d]++;
    nw = nbits / dw;
    exp_rv[d] += nw;
    if (nbits % dw != 0) exp_pt[d]++;
    wait_clk(8);
    for (int i = 0; i < nw; i++) begin
      if (d == 0) rxw = (rxq0.size() > 0) ? rxq0.pop_front() : 32'hxxxx_xxxx;
      else        rxw = (rxq1.size() > 0) ? rxq1.pop_front() : 32'hxxxx_xxxx;
      chk({tag, "_rx_word"}, rxw, (i == 0) ? w0 : w1);
      chk({tag, "_miso_word"}, got[i], exp_tx[i]);
    end
    chk({tag, "_miso_oe_idle"}, {31'd0, miso_oe[d]}, 32'd0);
    chk({tag, "_miso_idle"}, {31'd0, miso[d]}, 32'd0);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready[d]}, {31'd0, !hold_full[d]});
    chk_counts(d, tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flags"},
        {16'd0, miso, miso_oe, rx_valid, frame_start, frame_end, tx_underrun, rx_partial, tx_ready},
        32'h0000_0003);
    chk({tag, "_rx_data8"}, {24'd0, rx_data8}, 32'd0);
    chk({tag, "_rx_data16"}, {16'd0, rx_data16}, 32'd0);
  endtask

  initial begin
    int d, dw, nbits, wr_at, sel;
    logic [1:0] mode;
    logic [31:0] mask, w0, w1;
    reset = 1'b1;
    sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    ssel_n = 2'b11; tx_valid = 2'b00; tx_data8 = '0; tx_data16 = '0;
    for (int i = 0; i < 2; i++) begin
      hold_full[i] = 1'b0; hold_val[i] = '0;
      exp_fs[i] = 0; exp_fe[i] = 0; exp_rv[i] = 0; exp_ur[i] = 0; exp_pt[i] = 0;
    end
    wait_clk(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    wait_clk(6);

    // Mode 0 basic word; a second holding word mid-frame avoids any underrun.
    wr_m(0, 32'h3C);
    run_frame(0, 2'b00, 8, 32'hA5, 32'h0, 3, 32'h55, "mode0");
    chk("mode0_no_underrun", exp_ur[0], 0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      wr_m(0, 32'hC3);
      run_frame(0, 2'(m), 8, 32'h5A, 32'h0, -1, 32'h0, $sformatf("mode%0d", m));
    end

    // 16-bit LSB-first back-to-back words, second tx word written after first load
    wr_m(1, 32'hCAFE);
    run_frame(1, 2'b00, 32, 32'h1234, 32'hBEEF, 3, 32'h0F0F, "dw16_lsb");

    // Underrun at frame start, holding refilled mid-word
    run_frame(0, 2'b00, 16, 32'h11, 32'h22, 2, 32'h77, "underrun");

    // Partial frame then a clean one
    wr_m(0, 32'h99);
    run_frame(0, 2'b00, 5, 32'h6B, 32'h0, -1, 32'h0, "partial");
    wr_m(0, 32'h42);
    run_frame(0, 2'b00, 8, 32'h81, 32'h0, -1, 32'h0, "after_partial");

    // Reset in mid-frame with select held low through release
    cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
    wait_clk(4);
    ssel_n[0] = 1'b0;
    exp_fs[0]++;
    void'(load_m(0));
    wait_clk(8);
    repeat (2) begin
      sck = 1'b1; wait_clk(8); sck = 1'b0; wait_clk(8);
    end
    reset = 1'b1;
    wait_clk(2);
    chk_reset_vals("mid_reset");
    hold_full[0] = 1'b0;
    hold_full[1] = 1'b0;
    reset = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom_range(0, 1));
      wait_clk(4); sck = 1'b1; wait_clk(8); sck = 1'b0; wait_clk(4);
    end
    ssel_n[0] = 1'b1;
    wait_clk(10);
    chk_counts(0, "post_reset_ignored");
    chk("post_reset_rx_data", {24'd0, rx_data8}, 32'd0);
    wr_m(0, 32'hE7);
    run_frame(0, 2'b01, 8, 32'h3D, 32'h0, -1, 32'h0, "rearmed");

    // Randomised frames against the model
    for (int it = 0; it < 10; it++) begin
      d    = int'($urandom_range(0, 1));
      dw   = (d == 1) ? 16 : 8;
      mask = (32'd1 << dw) - 32'd1;
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1 && !hold_full[d]) wr_m(d, $urandom & mask);
      sel   = int'($urandom_range(0, 2));
      nbits = (sel == 0) ? dw : (sel == 1) ? 2 * dw : int'($urandom_range(1, dw - 1));
      wr_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nbits - 1)) : -1;
      w0 = $urandom & mask;
      w1 = $urandom & mask;
      run_frame(d, mode, nbits, w0, w1, wr_at, $urandom & mask, $sformatf("rand%0d", it));
    end
    chk_counts(1, "final16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
